// File: rtl/lsu_bus_if.sv
// Load/store unit bridging the core datapath to the data-memory bus.
// Handshakes on ACKD_n with an optional timeout and flags bad accesses.
module lsu_bus_if #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15,
    parameter int TW      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            stall,
    output logic [XLEN-1:0] DAD,
    output logic            MREQ,
    output logic            WRITE,
    output logic [1:0]      SIZE,
    input  logic            ACKD_n,
    input  logic [XLEN-1:0] DDT_i,
    output logic [XLEN-1:0] DDT_o,
    output logic            DDT_oe
);

    localparam int OW = $clog2(XLEN / 8);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] TMAX = TW'(TO_EN ? TIMEOUT - 1 : 0);
    localparam logic [XLEN-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    state_e        state_q;
    logic [TW-1:0] cnt_q;
    logic [OW-1:0] off_q;
    logic          uns_q;

    logic            legal;
    logic [XLEN-1:0] wrep;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sgn;
    logic [XLEN-1:0] ext;

    assign req_ready = (state_q == IDLE);
    assign stall     = (state_q == IDLE && req_valid) || (state_q == BUS);

    always_comb begin
        legal = 1'b1;
        case (req_size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~req_addr[0];
            2'b10:   legal = (req_addr[1:0] == 2'b00);
            default: legal = (XLEN == 64) && (req_addr[2:0] == 3'b000);
        endcase
    end

    // Replicate the right-justified store data across every lane of its size.
    always_comb begin
        wrep = req_wdata;
        for (int i = 0; i < XLEN / 8; i++) begin
            case (req_size)
                2'b00:   wrep[8*i +: 8] = req_wdata[7:0];
                2'b01:   wrep[8*i +: 8] = req_wdata[8*(i%2) +: 8];
                2'b10:   wrep[8*i +: 8] = req_wdata[8*(i%4) +: 8];
                default: wrep[8*i +: 8] = req_wdata[8*i +: 8];
            endcase
        end
    end

    always_comb begin
        shifted = DDT_i >> {off_q, 3'b000};
        mask    = '1;
        sgn     = 1'b0;
        case (SIZE)
            2'b00: begin
                mask = (ONE << 8) - ONE;
                sgn  = shifted[7];
            end
            2'b01: begin
                mask = (ONE << 16) - ONE;
                sgn  = shifted[15];
            end
            2'b10: begin
                mask = (ONE << 32) - ONE;
                sgn  = shifted[31];
            end
            default: begin
                mask = '1;
                sgn  = 1'b0;
            end
        endcase
        ext = (shifted & mask) | ({XLEN{sgn & ~uns_q}} & ~mask);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            off_q      <= '0;
            uns_q      <= 1'b0;
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            DDT_oe     <= 1'b0;
            SIZE       <= 2'b00;
            DAD        <= '0;
            DDT_o      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        uns_q <= req_unsigned;
                        off_q <= req_addr[OW-1:0];
                        SIZE  <= req_size;
                        cnt_q <= '0;
                        if (legal) begin
                            state_q <= BUS;
                            MREQ    <= 1'b1;
                            WRITE   <= req_write;
                            DDT_oe  <= req_write;
                            DAD     <= {req_addr[XLEN-1:OW], {OW{1'b0}}};
                            DDT_o   <= wrep;
                        end else begin
                            state_q    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                BUS: begin
                    if (!ACKD_n) begin
                        state_q    <= RESP;
                        MREQ       <= 1'b0;
                        WRITE      <= 1'b0;
                        DDT_oe     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= WRITE ? '0 : ext;
                    end else if (TO_EN && cnt_q == TMAX) begin
                        state_q    <= RESP;
                        MREQ       <= 1'b0;
                        WRITE      <= 1'b0;
                        DDT_oe     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Random and directed bench for lsu_bus_if against a byte-level model.
// Runs a 32-bit unit (TIMEOUT=4) and a 64-bit unit (no timeout) in lockstep.
module tb_lsu_bus_if;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rv_a, rv_b;
    logic        req_write, req_unsigned, ACKD_n;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata, ddt;

    logic        a_ready, a_rv, a_err, a_stall, a_mreq, a_write, a_oe;
    logic [1:0]  a_size;
    logic [31:0] a_rdata, a_dad, a_do;
    logic        b_ready, b_rv, b_err, b_stall, b_mreq, b_write, b_oe;
    logic [1:0]  b_size;
    logic [63:0] b_rdata, b_dad, b_do;

    lsu_bus_if #(.XLEN(32), .TIMEOUT(4), .TW(4)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(rv_a), .req_ready(a_ready),
        .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_err(a_err),
        .stall(a_stall), .DAD(a_dad), .MREQ(a_mreq), .WRITE(a_write),
        .SIZE(a_size), .ACKD_n(ACKD_n), .DDT_i(ddt[31:0]),
        .DDT_o(a_do), .DDT_oe(a_oe)
    );

    lsu_bus_if #(.XLEN(64), .TIMEOUT(0), .TW(8)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(rv_b), .req_ready(b_ready),
        .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_err(b_err),
        .stall(b_stall), .DAD(b_dad), .MREQ(b_mreq), .WRITE(b_write),
        .SIZE(b_size), .ACKD_n(ACKD_n), .DDT_i(ddt),
        .DDT_o(b_do), .DDT_oe(b_oe)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ld_model(int xb, logic [63:0] d,
            logic [1:0] sz, logic u, logic [63:0] ad);
        int off = int'(ad % 64'(xb));
        int nb = 1 << sz;
        logic [63:0] v, m;
        if (xb == 4) d &= 64'hFFFF_FFFF;
        v = d >> (8 * off);
        m = (nb == 8) ? '1 : (64'd1 << (8 * nb)) - 64'd1;
        v &= m;
        if (!u && v[8*nb-1]) v |= ~m;
        if (xb == 4) v &= 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] st_model(int xb, logic [63:0] wd,
            logic [1:0] sz);
        logic [63:0] r = '0;
        int nb = 1 << sz;
        for (int i = 0; i < xb; i++) r[8*i +: 8] = wd[8*(i%nb) +: 8];
        return r;
    endfunction

    int          e_lat[2], e_mc[2], mc[2], oc[2];
    logic        e_err[2], e_lg[2], done[2], cur_w;
    logic [1:0]  cur_sz;
    logic [63:0] e_rd[2], e_dad[2], e_do[2];

    task automatic observe(input int d, input int k, input logic rv,
            input logic err, input logic stl, input logic rdy,
            input logic mreq, input logic oe, input logic wr,
            input logic [1:0] sz, input logic [63:0] rd,
            input logic [63:0] dad, input logic [63:0] dout);
        string n = d ? "b" : "a";
        if (done[d]) begin
            check({"rv_after_", n}, rv, 1'b0);
            return;
        end
        if (mreq) begin
            mc[d]++;
            check({"stall_bus_", n}, stl, 1'b1);
        end
        if (oe) oc[d]++;
        if (k == 1 && e_lg[d]) begin
            check({"dad_", n}, dad, e_dad[d]);
            check({"size_", n}, sz, cur_sz);
            check({"write_", n}, wr, cur_w);
            check({"oe_", n}, oe, cur_w);
            if (cur_w) check({"ddto_", n}, dout, e_do[d]);
        end
        if (rv) begin
            check({"lat_", n}, k, e_lat[d]);
            check({"err_", n}, err, e_err[d]);
            check({"rdata_", n}, rd, e_rd[d]);
            check({"mreq_cyc_", n}, mc[d], e_mc[d]);
            check({"oe_cyc_", n}, oc[d], cur_w ? e_mc[d] : 0);
            check({"resp_stall_rdy_", n}, {stl, rdy}, 2'b00);
            done[d] = 1'b1;
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic txn(input logic w, input logic [1:0] sz, input logic u,
            input logic [63:0] ad, input logic [63:0] wd,
            input logic [63:0] dd, input int waits);
        for (int d = 0; d < 2; d++) begin
            int xb = d ? 8 : 4;
            int tmo = d ? 0 : 4;
            logic [63:0] xm = d ? '1 : 64'hFFFF_FFFF;
            logic [63:0] a = ad & xm;
            int nb = 1 << sz;
            e_lg[d] = (a % 64'(nb) == 0) && !(d == 0 && sz == 2'b11);
            if (!e_lg[d]) begin
                e_lat[d] = 1; e_err[d] = 1'b1; e_rd[d] = '0;
            end else if (tmo != 0 && waits >= tmo) begin
                e_lat[d] = tmo + 1; e_err[d] = 1'b1; e_rd[d] = '0;
            end else begin
                e_lat[d] = waits + 2; e_err[d] = 1'b0;
                e_rd[d] = w ? '0 : ld_model(xb, dd, sz, u, a);
            end
            e_mc[d] = e_lg[d] ? e_lat[d] - 1 : 0;
            e_dad[d] = a & ~64'(xb - 1);
            e_do[d] = st_model(xb, wd & xm, sz);
            mc[d] = 0; oc[d] = 0; done[d] = 1'b0;
        end
        cur_w = w; cur_sz = sz;
        req_write = w; req_size = sz; req_unsigned = u;
        req_addr = ad; req_wdata = wd; ddt = dd;
        rv_a = 1'b1; rv_b = 1'b1; ACKD_n = 1'b1;
        @(negedge clk);
        check("ready_idle", {a_ready, b_ready}, 2'b11);
        check("stall_idle", {a_stall, b_stall}, 2'b11);
        @(posedge clk); #1;
        rv_a = 1'b0; rv_b = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        for (int k = 1; k <= 300 && !(done[0] && done[1]); k++) begin
            ACKD_n = !(k == waits + 1);
            @(negedge clk);
            observe(0, k, a_rv, a_err, a_stall, a_ready, a_mreq, a_oe,
                    a_write, a_size, 64'(a_rdata), 64'(a_dad), 64'(a_do));
            observe(1, k, b_rv, b_err, b_stall, b_ready, b_mreq, b_oe,
                    b_write, b_size, b_rdata, b_dad, b_do);
            @(posedge clk); #1;
        end
        ACKD_n = 1'b1;
        check("resp_seen", {done[0], done[1]}, 2'b11);
    endtask

    task automatic reset_mid();
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 64'h10; ddt = '1; ACKD_n = 1'b1;
        rv_a = 1'b1; rv_b = 1'b1;
        @(posedge clk); #1;
        rv_a = 1'b0; rv_b = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mreq_bus2", {a_mreq, b_mreq}, 2'b11);
        #1 rst = 1'b0;
        #1;
        check("mreq_async", {a_mreq, b_mreq, a_oe, b_oe}, 4'b0);
        check("ready_async", {a_ready, b_ready}, 2'b11);
        repeat (2) begin
            @(negedge clk);
            check("rv_in_rst", {a_rv, b_rv}, 2'b00);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rv_after_rst", {a_rv, b_rv}, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        rv_a = 1'b0; rv_b = 1'b0;
        req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; ddt = '0; ACKD_n = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_ctl_a", {a_mreq, a_write, a_oe, a_size, a_rv, a_err}, 0);
        check("rst_ctl_b", {b_mreq, b_write, b_oe, b_size, b_rv, b_err}, 0);
        check("rst_dat_a", 64'(a_dad | a_do | a_rdata), 0);
        check("rst_dat_b", b_dad | b_do | b_rdata, 0);
        check("rst_rdy", {a_ready, b_ready, a_stall, b_stall}, 4'b1100);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        txn(1'b0, 2'b00, 1'b0, 64'h1003, '0, 64'h80AA5500, 0);
        txn(1'b0, 2'b00, 1'b1, 64'h1003, '0, 64'h80AA5500, 0);
        txn(1'b1, 2'b01, 1'b0, 64'h2002, 64'h1234BEEF, '0, 3);
        txn(1'b0, 2'b10, 1'b0, 64'h3001, '0, '1, 0);
        txn(1'b0, 2'b11, 1'b0, 64'h3000, '0, 64'h8877665544332211, 1);
        txn(1'b0, 2'b10, 1'b0, 64'h4, '0, 64'h8000000100000000, 0);
        txn(1'b1, 2'b10, 1'b0, 64'h8, 64'hCAFEF00D, '0, 4);
        txn(1'b0, 2'b10, 1'b1, 64'hC, '0, 64'h89ABCDEF01234567, 100);
        reset_mid();
        txn(1'b0, 2'b01, 1'b0, 64'h16, '0, 64'h0000F00D00000000, 2);

        for (int i = 0; i < 60; i++) begin
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            logic [63:0] ad = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) ad &= ~((64'd1 << sz) - 64'd1);
            txn(1'($urandom), sz, 1'($urandom), ad,
                {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
